// File: rtl/sync_frame_tx.sv
// rtl/sync_frame_tx.sv - serial frame transmitter: sync code, payload, idle gap
//
// Purpose:
//   Takes one payload word per frame over a valid/ready handshake and shifts
//   it out on a single serial line, one bit per clock:
//     SYNC_CODE (SYNC_LEN bits, bit 0 first),
//     payload   (DATA_W bits, LSB first),
//     idle gap  (GAP_CYCLES cycles of 0, then one IDLE cycle before the next accept).
//   The idle level is 0 and SYNC_CODE[0] is 1, so a quiet line never looks like
//   the start of a sync code to the receiving detector.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset; aborts any frame in flight
//   tx_data      payload word, sampled only on the accept edge
//   tx_valid     payload offered
//   tx_ready     high only in IDLE (combinational decode of state)
//   data_out     registered serial line, idle level 0
//   frame_active high while a sync or payload bit is on data_out
//   done         one-cycle pulse in the cycle after the last payload bit

module sync_frame_tx #(
  parameter int                  SYNC_LEN   = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_CODE  = 4'b1001,
  parameter int                  DATA_W     = 8,
  parameter int                  GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              data_out,
  output logic              frame_active,
  output logic              done
);

  // One counter width serves both the bit and the gap counters.
  localparam int MAX_A = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int MAX_N = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              data_out_q, data_out_d;
  logic              frame_active_q, frame_active_d;
  logic              done_q, done_d;

  // Sync bit selected by bit_cnt. Masking the whole code keeps every code bit
  // in use and avoids an index wider than the code itself.
  logic [SYNC_LEN-1:0] sync_mask;
  logic                sync_bit;

  always_comb begin
    sync_mask = SYNC_LEN'(1) << bit_cnt_q;
    sync_bit  = |(SYNC_CODE & sync_mask);
  end

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= CNT_ZERO;
      gap_cnt_q      <= CNT_ZERO;
      shreg_q        <= '0;
      data_out_q     <= 1'b0;
      frame_active_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      shreg_q        <= shreg_d;
      data_out_q     <= data_out_d;
      frame_active_q <= frame_active_d;
      done_q         <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (bit_cnt_q == SYNC_LAST) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (bit_cnt_q == DATA_LAST) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic. The line is low unless a state drives a bit;
  // done is a pulse, so it also defaults low.
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    shreg_d        = shreg_q;
    data_out_d     = 1'b0;
    frame_active_d = frame_active_q;
    done_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        frame_active_d = 1'b0;
        if (tx_valid) begin
          // Accept edge: sync bit 0 goes on the line immediately.
          shreg_d        = tx_data;
          data_out_d     = sync_bit;
          frame_active_d = 1'b1;
          bit_cnt_d      = CNT_ONE;
        end
      end

      ST_SYNC: begin
        if (bit_cnt_q == SYNC_LAST) begin
          // Last sync bit already sent; first payload bit follows without a bubble.
          data_out_d = shreg_q[0];
          shreg_d    = shreg_q >> 1;
          bit_cnt_d  = CNT_ONE;
        end else begin
          data_out_d = sync_bit;
          bit_cnt_d  = bit_cnt_q + CNT_ONE;
        end
      end

      ST_PAYLOAD: begin
        if (bit_cnt_q == DATA_LAST) begin
          frame_active_d = 1'b0;
          done_d         = 1'b1;
          bit_cnt_d      = CNT_ZERO;
          gap_cnt_d      = CNT_ONE;
        end else begin
          data_out_d = shreg_q[0];
          shreg_d    = shreg_q >> 1;
          bit_cnt_d  = bit_cnt_q + CNT_ONE;
        end
      end

      ST_GAP: begin
        frame_active_d = 1'b0;
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = CNT_ZERO;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_ONE;
        end
      end

      default: begin
        frame_active_d = 1'b0;
        bit_cnt_d      = CNT_ZERO;
        gap_cnt_d      = CNT_ZERO;
      end
    endcase
  end

  assign tx_ready     = (state_q == ST_IDLE);
  assign data_out     = data_out_q;
  assign frame_active = frame_active_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb/tb_sync_frame_tx.sv - scoreboard bench for sync_frame_tx
module tb_sync_frame_tx;

  localparam int              SYNC_LEN  = 4;
  localparam logic [3:0]      SYNC_CODE = 4'b1001;
  localparam int              DATA_W    = 8;
  localparam int              GAP       = 1;
  localparam int              D2_W      = 4;
  localparam int              D2_GAP    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready, data_out, frame_active, done;

  logic [D2_W-1:0]   tx_data2;
  logic              tx_valid2;
  logic              tx_ready2, data_out2, frame_active2, done2;

  sync_frame_tx #(
    .SYNC_LEN(SYNC_LEN), .SYNC_CODE(SYNC_CODE), .DATA_W(DATA_W), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .data_out(data_out), .frame_active(frame_active), .done(done)
  );

  sync_frame_tx #(
    .SYNC_LEN(SYNC_LEN), .SYNC_CODE(SYNC_CODE), .DATA_W(D2_W), .GAP_CYCLES(D2_GAP)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .data_out(data_out2), .frame_active(frame_active2), .done(done2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: an accepted word expands into its whole per-cycle
  // picture {data_out, frame_active, done, tx_ready}; after the frame the
  // line is idle with ready high. A word is accepted only in a cycle where
  // the model itself shows ready.
  logic [3:0] pending[$];
  logic [3:0] sb[$];
  logic [3:0] model_e;
  logic       model_rdy = 1'b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      pending.delete();
      model_rdy = 1'b1;
      sb.push_back(4'b0001);
    end else begin
      if (model_rdy && tx_valid) begin
        for (int i = 0; i < SYNC_LEN; i++) pending.push_back({SYNC_CODE[i], 1'b1, 1'b0, 1'b0});
        for (int j = 0; j < DATA_W; j++) pending.push_back({tx_data[j], 1'b1, 1'b0, 1'b0});
        pending.push_back(4'b0010);
        for (int g = 0; g < GAP - 1; g++) pending.push_back(4'b0000);
      end
      if (pending.size() > 0) model_e = pending.pop_front();
      else model_e = 4'b0001;
      model_rdy = model_e[0];
      sb.push_back(model_e);
    end
  end

  // Monitor: compares what the DUT presents each cycle against the scoreboard.
  always begin
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow at cycle %0d: no expected entry", cyc);
    end else begin
      check("line", 32'({data_out, frame_active, done, tx_ready}), 32'(sb.pop_front()));
    end
  end

  // frame_active rising cycles, for the frame period check.
  int   rises[$];
  logic fa_prev = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (frame_active && !fa_prev) rises.push_back(cyc);
    fa_prev = frame_active;
  end

  // Receive-side sync detector on the looped-back line (LSB-first receive).
  logic [SYNC_LEN-1:0] win = '0;
  int det_count = 0;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) win = '0;
    else begin
      win = {data_out, win[SYNC_LEN-1:1]};
      if (win == SYNC_CODE) det_count++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = DATA_W'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [3:0] exp2[$];
  logic [D2_W-1:0] p2;

  initial begin
    rst_n     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_valid2 = 1'b0;
    tx_data2  = '0;

    // Reset state.
    idle(3);
    check("rst_data_out", 32'(data_out), 32'(0));
    check("rst_frame_active", 32'(frame_active), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    rst_n = 1'b1;
    idle(3);

    // Single frame of 8'hA5.
    send(8'hA5);
    idle(18);

    // Back-to-back: 8'h00 then 8'hFF with tx_valid held.
    rises.delete();
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    idle(5);
    tx_data  = 8'hFF;
    idle(15);
    tx_valid = 1'b0;
    idle(16);
    check("b2b_frame_count", 32'(rises.size()), 32'(2));
    if (rises.size() >= 2)
      check("b2b_period", 32'(rises[1] - rises[0]), 32'(SYNC_LEN + DATA_W + GAP + 1));

    // Captured payload is immune to mid-frame input activity.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      tx_data  = 8'hFF;
      tx_valid = 1'($urandom);
    end
    tx_valid = 1'b0;
    idle(20);

    // Reset during payload bit 3.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = DATA_W'($urandom);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 32'(0));
    check("midrst_frame_active", 32'(frame_active), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_tx_ready", 32'(tx_ready), 32'(1));
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send(8'h5A);
    idle(18);

    // Loopback detect: once per frame for 8'h00, an extra alias for 8'h09.
    det_count = 0;
    send(8'h00);
    idle(18);
    check("detect_payload_00", 32'(det_count), 32'(1));
    det_count = 0;
    send(8'h09);
    idle(18);
    check("detect_payload_09", 32'(det_count), 32'(2));

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      tx_valid = (($urandom % 3) != 0);
      tx_data  = DATA_W'($urandom);
    end
    tx_valid = 1'b0;
    idle(20);

    // Narrow instance: DATA_W=4, GAP_CYCLES=3, payload 4'hA held.
    p2 = 4'hA;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < SYNC_LEN; i++) exp2.push_back({SYNC_CODE[i], 1'b1, 1'b0, 1'b0});
      for (int j = 0; j < D2_W; j++) exp2.push_back({p2[j], 1'b1, 1'b0, 1'b0});
      exp2.push_back(4'b0010);
      for (int g = 0; g < D2_GAP - 1; g++) exp2.push_back(4'b0000);
      exp2.push_back(4'b0001);
    end
    @(negedge clk);
    tx_valid2 = 1'b1;
    tx_data2  = p2;
    for (int k = 0; k < 2 * (SYNC_LEN + D2_W + D2_GAP + 1); k++) begin
      @(posedge clk);
      #1;
      check("narrow_line", 32'({data_out2, frame_active2, done2, tx_ready2}), 32'(exp2[k]));
    end
    @(negedge clk);
    tx_valid2 = 1'b0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_frame_tx.md
Name: sync_frame_tx

Overview:
- Serial frame transmitter: the sending end of the sync-code link whose receive side is the sequence_detect unit.
- Accepts one parallel payload word per frame over a valid/ready handshake.
- Emits on a single serial line, one bit per clk: the sync code, then the payload, then a forced idle gap.
- Bit order is LSB first for both fields, so sync bit 0 goes out first, which is the order sequence_detect matches in.

Parameters:
- SYNC_CODE, 4'b1001, sync pattern; bit 0 transmitted first.
- SYNC_LEN, 4, number of sync bits; must equal the SYNC_CODE width.
- DATA_W, 8, payload width in bits, range 1..32.
- GAP_CYCLES, 1, number of idle-level cycles forced after each frame, minimum 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  payload word; sampled only at the handshake edge.
- tx_valid  input  1  payload offered.
- tx_ready  output  1  block can accept a frame; high only in IDLE.
- data_out  output  1  serial line, registered; idle level 0.
- frame_active  output  1  high while a sync or payload bit is on data_out.
- done  output  1  one-cycle pulse when the frame finishes.

Behaviour:
- Reset: asserting rst_n low immediately forces these values, at any time including mid-frame, with no partial frame resumed:
  - state = IDLE
  - data_out = 0
  - frame_active = 0
  - done = 0
  - bit and gap counters = 0
  - payload shift register = 0
- tx_ready is decoded combinationally from state: it equals (state == IDLE).
- States:
  - IDLE: tx_ready = 1, data_out = 0. On an edge with tx_valid = 1:
    - capture tx_data into the shift register
    - data_out <= SYNC_CODE[0], frame_active <= 1
    - bit_cnt <= 1, go to SYNC
    - with tx_valid = 0, stay in IDLE.
  - SYNC: each edge drives data_out <= SYNC_CODE[bit_cnt] and increments bit_cnt.
    - At the edge where bit_cnt == SYNC_LEN: drive data_out <= shreg[0], shift the register right, set bit_cnt <= 1, go to PAYLOAD.
  - PAYLOAD: each edge drives data_out <= shreg[0], shifts right and increments bit_cnt.
    - At the edge where bit_cnt == DATA_W:
      - data_out <= 0, frame_active <= 0, done <= 1
      - gap_cnt <= 1, go to GAP.
  - GAP: data_out stays 0 and done clears.
    - At the edge where gap_cnt == GAP_CYCLES, go to IDLE; otherwise increment gap_cnt.
  - Any unused encoding returns to IDLE on the next edge.
- Timing, with the accept edge called N:
  - Sync bit i is on the line during the cycle after edge N+i, for i = 0..SYNC_LEN-1.
  - Payload bit j is on the line during the cycle after edge N+SYNC_LEN+j.
  - Frame length is SYNC_LEN+DATA_W cycles (12 with defaults). frame_active is high for exactly those cycles.
  - done is high for the single cycle after edge N+SYNC_LEN+DATA_W.
- Back-to-back frames:
  - With tx_valid held high, the line is low for GAP_CYCLES+1 cycles between frames (2 with defaults).
  - Frame period is SYNC_LEN+DATA_W+GAP_CYCLES+1 cycles (14 with defaults).
- Changes on tx_data or tx_valid outside IDLE are ignored. The captured payload is immune to tx_data changes mid-frame.
- The idle line is 0 and SYNC_CODE[0] is 1, so idle never resembles the start of a sync code.
- Counter width is clog2(max(SYNC_LEN, DATA_W, GAP_CYCLES)+1).

Test Plan:
1. Reset release, then tx_valid=1 with tx_data=8'hA5 for one cycle:
   - tx_ready falls after the accept edge.
   - data_out sequence is 1,0,0,1, 1,0,1,0,0,1,0,1, then 0.
   - frame_active is high for 12 cycles.
   - done pulses once, in the cycle after the last payload bit.
   - tx_ready returns high after 1 gap cycle.
2. tx_valid held high with tx_data 8'h00 then 8'hFF:
   - Two frames are sent, separated by exactly 2 low cycles.
   - Payloads are 8 zeros, then 8 ones.
   - Frame period is 14 cycles.
3. Accept 8'h3C, then drive tx_data=8'hFF and toggle tx_valid during the frame:
   - Transmitted payload is still 0,0,1,1,1,1,0,0.
   - No second frame starts until IDLE is reached.
4. Assert rst_n low during payload bit 3:
   - data_out, frame_active and done go to 0 immediately.
   - After release, tx_ready = 1 and the next frame starts cleanly from the sync code.
5. Loopback of data_out into sequence_detect, payload 8'h00:
   - Detector detected pulses once per frame, tied to the sync code.
   - A payload of 8'h09 (LSB-first 1,0,0,1) produces an additional detect, which documents the aliasing.
6. GAP_CYCLES=3, DATA_W=4, tx_valid held high with payload 4'hA:
   - Line sequence is 1,0,0,1, 0,1,0,1, then 4 zeros, then the next frame.
   - Frame period is 12 cycles.
